// File: rtl/scan_pkg.sv
// Shared definitions for the digit scan sequencer.
// Holds the FSM state encoding and the default dwell/guard/prescaler constants
// used as parameter defaults by digit_scan_sequencer and scan_prescaler.
package scan_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam int unsigned DefaultDiv   = 50000;
  localparam int unsigned DefaultBlank = 2;
  localparam int unsigned DefaultCntW  = 16;

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-DIV dwell counter for the digit scan sequencer.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   clr  - force the count to 0 (takes priority over en)
//   en   - advance the count by one this cycle
//   pcnt - current count, 0..DIV-1
//   wrap - high in the cycle where the count is DIV-1 and is about to return to 0
module scan_prescaler
  import scan_pkg::*;
#(
  parameter int unsigned DIV   = DefaultDiv,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] pcnt,
  output logic             wrap
);

  logic [CNT_W-1:0] pcnt_q, pcnt_d;

  // A clear in the same cycle cancels the wrap, so a restart never produces a tick.
  assign wrap = en && !clr && (pcnt_q == CNT_W'(DIV - 1));
  assign pcnt = pcnt_q;

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = wrap ? '0 : pcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/digit_scan_sequencer.sv
// Digit-select sequencer for a multiplexed display.
// Steps a 2-bit select through digits 0..last_q, holding each for DIV cycles, blanks the
// decoder for the first BLANK cycles of every dwell, and pulses tick/frame_done on advances.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   start      - pulse: (re)start scanning at digit 0, samples single and last
//   stop       - pulse: abort scanning (wins over start)
//   single     - 1 = run one frame then return to idle, 0 = continuous
//   last       - highest digit index to scan
//   sel        - digit select to the 2-to-4 decoder
//   sel_valid  - decoder enable, 0 blanks all digits
//   tick       - pulse on every digit advance
//   frame_done - pulse when the scan wraps from last_q to 0
//   busy       - high while scanning
// All outputs are registered.
module digit_scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned DIV   = DefaultDiv,
  parameter int unsigned BLANK = DefaultBlank,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       single,
  input  logic [1:0] last,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       tick,
  output logic       frame_done,
  output logic       busy
);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q;
  logic             single_q;
  logic             sel_valid_q, sel_valid_d;
  logic             tick_q, tick_d;
  logic             frame_done_q, frame_done_d;

  logic             restart;
  logic             at_last;
  logic             clr;
  logic             en;
  logic             wrap;
  logic             blank_done;
  logic [CNT_W-1:0] pcnt;

  assign restart = start && !stop;
  assign at_last = (sel_q == last_q);
  // Counter sits at 0 in idle and is zeroed on any start/stop.
  assign clr     = (state_q == StIdle) || start || stop;
  assign en      = (state_q == StRun);

  scan_prescaler #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (en),
    .pcnt (pcnt),
    .wrap (wrap)
  );

  // blank_done: the count held in the next cycle will be >= BLANK. The next count is 0 after
  // a clear or wrap, otherwise pcnt+1, so the test reduces to pcnt >= BLANK-1.
  if (BLANK == 0) begin : g_blank_none
    assign blank_done = 1'b1;
  end else if (BLANK == 1) begin : g_blank_one
    assign blank_done = !clr && !wrap;
  end else begin : g_blank_multi
    assign blank_done = !clr && !wrap && (pcnt >= CNT_W'(BLANK - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (restart) state_d = StRun;
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
        end else if (wrap && at_last && single_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output next-state logic; wrap already excludes cycles with start or stop.
  always_comb begin
    sel_d        = sel_q;
    tick_d       = wrap;
    frame_done_d = wrap && at_last;
    sel_valid_d  = (state_d == StRun) && blank_done;
    if ((state_d == StIdle) || restart) begin
      sel_d = 2'd0;
    end else if (wrap) begin
      sel_d = at_last ? 2'd0 : sel_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q        <= 2'd0;
      sel_valid_q  <= 1'b0;
      tick_q       <= 1'b0;
      frame_done_q <= 1'b0;
      last_q       <= 2'd0;
      single_q     <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      sel_valid_q  <= sel_valid_d;
      tick_q       <= tick_d;
      frame_done_q <= frame_done_d;
      if (restart) begin
        last_q   <= last;
        single_q <= single;
      end
    end
  end

  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign tick       = tick_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == StRun);

endmodule

// File: tb/tb_digit_scan_sequencer.sv
// Bench for digit_scan_sequencer: instance A (DIV=4, BLANK=1) and instance B (DIV=2, BLANK=0)
// share all inputs and are each compared every cycle against a time-based reference model.
module tb_digit_scan_sequencer;

  localparam int DIV_A = 4;
  localparam int BLANK_A = 1;
  localparam int DIV_B = 2;
  localparam int BLANK_B = 0;

  logic       clk = 1'b0;
  logic       rst, start, stop, single;
  logic [1:0] last;

  logic [1:0] sel_a, sel_b;
  logic       sel_valid_a, tick_a, frame_done_a, busy_a;
  logic       sel_valid_b, tick_b, frame_done_b, busy_b;

  logic [5:0] obs_a, obs_b;
  logic [5:0] exp_v [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  digit_scan_sequencer #(
    .DIV   (DIV_A),
    .BLANK (BLANK_A),
    .CNT_W (16)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .single     (single),
    .last       (last),
    .sel        (sel_a),
    .sel_valid  (sel_valid_a),
    .tick       (tick_a),
    .frame_done (frame_done_a),
    .busy       (busy_a)
  );

  digit_scan_sequencer #(
    .DIV   (DIV_B),
    .BLANK (BLANK_B),
    .CNT_W (16)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .single     (single),
    .last       (last),
    .sel        (sel_b),
    .sel_valid  (sel_valid_b),
    .tick       (tick_b),
    .frame_done (frame_done_b),
    .busy       (busy_b)
  );

  assign obs_a = {busy_a, sel_a, sel_valid_a, tick_a, frame_done_a};
  assign obs_b = {busy_b, sel_b, sel_valid_b, tick_b, frame_done_b};

  // Expected {busy, sel, sel_valid, tick, frame_done} from elapsed cycles t since start.
  function automatic logic [5:0] model_out(bit run, int t, int lq, bit evt, int d, int b);
    int dig;
    bit tk;
    if (!run) return {1'b0, 2'b00, 1'b0, evt, evt};
    dig = (t / d) % (lq + 1);
    tk  = (t > 0) && ((t % d) == 0);
    return {1'b1, 2'(dig), ((t % d) >= b), tk, (tk && (dig == 0))};
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_model
    localparam int D = (k == 0) ? DIV_A : DIV_B;
    localparam int B = (k == 0) ? BLANK_A : BLANK_B;
    bit run_m, sq_m, evt_m;
    int t_m, lq_m;
    always @(posedge clk) begin
      evt_m <= 1'b0;
      if (rst || stop) begin
        run_m <= 1'b0;
      end else if (start) begin
        run_m <= 1'b1;
        t_m   <= 0;
        lq_m  <= int'(last);
        sq_m  <= single;
      end else if (run_m) begin
        if (sq_m && (t_m + 1 == (lq_m + 1) * D)) begin
          run_m <= 1'b0;
          evt_m <= 1'b1;
        end else begin
          t_m <= t_m + 1;
        end
      end
    end
    assign exp_v[k] = model_out(run_m, t_m, lq_m, evt_m, D, B);
  end

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i <= 2) begin
        tests++;
        if (obs_a !== 6'b0) begin
          fails++;
          $display("FAIL reset_a[%0d] got %b want %b", i, obs_a, 6'b0);
        end
        tests++;
        if (obs_b !== 6'b0) begin
          fails++;
          $display("FAIL reset_b[%0d] got %b want %b", i, obs_b, 6'b0);
        end
      end
      rst   = (i < 2);
      start = (i == 1);  // reset must override this start
      stop  = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_continuous();
    int n_tick = 0, n_fd = 0, n_valid = 0;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      tests++;
      if (obs_a !== exp_v[0]) begin
        fails++;
        $display("FAIL cont_a[%0d] got %b want %b", i, obs_a, exp_v[0]);
      end
      tests++;
      if (obs_b !== exp_v[1]) begin
        fails++;
        $display("FAIL cont_b[%0d] got %b want %b", i, obs_b, exp_v[1]);
      end
      if (i > 0) begin
        n_tick  += int'(tick_a);
        n_fd    += int'(frame_done_a);
        n_valid += int'(sel_valid_a);
      end
      start = (i == 0); stop = 1'b0; single = 1'b0; last = 2'd3;
    end
    tests++;
    if (n_tick !== 9) begin
      fails++;
      $display("FAIL cont_tick_count got %0d want 9", n_tick);
    end
    tests++;
    if (n_fd !== 2) begin
      fails++;
      $display("FAIL cont_frame_count got %0d want 2", n_fd);
    end
    tests++;
    if (n_valid !== 30) begin
      fails++;
      $display("FAIL cont_valid_count got %0d want 30", n_valid);
    end
  endtask

  task automatic test_single();
    int n_tick = 0, n_fd = 0;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      tests++;
      if (obs_a !== exp_v[0]) begin
        fails++;
        $display("FAIL single_a[%0d] got %b want %b", i, obs_a, exp_v[0]);
      end
      tests++;
      if (obs_b !== exp_v[1]) begin
        fails++;
        $display("FAIL single_b[%0d] got %b want %b", i, obs_b, exp_v[1]);
      end
      if (i > 0) begin
        n_tick += int'(tick_a);
        n_fd   += int'(frame_done_a);
      end
      if (i == 9) begin
        tests++;
        if ({busy_a, sel_a, tick_a, frame_done_a} !== 5'b0_00_11) begin
          fails++;
          $display("FAIL single_wrap got %b want %b", {busy_a, sel_a, tick_a, frame_done_a},
                   5'b0_00_11);
        end
      end
      start = (i == 0); stop = 1'b0; single = 1'b1; last = 2'd1;
    end
    tests++;
    if (n_tick !== 2 || n_fd !== 1) begin
      fails++;
      $display("FAIL single_counts got tick=%0d fd=%0d want tick=2 fd=1", n_tick, n_fd);
    end
    single = 1'b0;
  endtask

  task automatic test_start_stop();
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      tests++;
      if (obs_a !== exp_v[0]) begin
        fails++;
        $display("FAIL stop_a[%0d] got %b want %b", i, obs_a, exp_v[0]);
      end
      tests++;
      if (obs_b !== exp_v[1]) begin
        fails++;
        $display("FAIL stop_b[%0d] got %b want %b", i, obs_b, exp_v[1]);
      end
      if (i == 9) begin
        tests++;
        if ({busy_a, tick_a, frame_done_a} !== 3'b000) begin
          fails++;
          $display("FAIL stop_wins got busy/tick/fd=%b want 000", {busy_a, tick_a, frame_done_a});
        end
      end
      // stop lands on the edge where dwell 1 would have ended
      start = (i == 0) || (i == 8); stop = (i == 8); single = 1'b0; last = 2'd2;
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_restart();
    int n_tick = 0, n_fd = 0, n_nz = 0;
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      tests++;
      if (obs_a !== exp_v[0]) begin
        fails++;
        $display("FAIL restart_a[%0d] got %b want %b", i, obs_a, exp_v[0]);
      end
      tests++;
      if (obs_b !== exp_v[1]) begin
        fails++;
        $display("FAIL restart_b[%0d] got %b want %b", i, obs_b, exp_v[1]);
      end
      if (i == 7) begin
        tests++;
        if (sel_a !== 2'd1) begin
          fails++;
          $display("FAIL restart_pre_sel got %0d want 1", sel_a);
        end
      end
      if (i == 8) begin
        tests++;
        if ({sel_a, sel_valid_a, tick_a} !== 4'b0000) begin
          fails++;
          $display("FAIL restart_blank got %b want 0000", {sel_a, sel_valid_a, tick_a});
        end
      end
      if (i >= 8) begin
        n_tick += int'(tick_a);
        n_fd   += int'(frame_done_a);
        n_nz   += int'(sel_a != 2'd0);
      end
      start = (i == 0) || (i == 7); stop = 1'b0; single = 1'b0; last = (i < 7) ? 2'd3 : 2'd0;
    end
    tests++;
    if (n_tick !== 5 || n_fd !== 5 || n_nz !== 0) begin
      fails++;
      $display("FAIL restart_counts got tick=%0d fd=%0d nz=%0d want 5 5 0", n_tick, n_fd, n_nz);
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      tests++;
      if (obs_a !== exp_v[0]) begin
        fails++;
        $display("FAIL rstrun_a[%0d] got %b want %b", i, obs_a, exp_v[0]);
      end
      tests++;
      if (obs_b !== exp_v[1]) begin
        fails++;
        $display("FAIL rstrun_b[%0d] got %b want %b", i, obs_b, exp_v[1]);
      end
      if (i == 10) begin
        tests++;
        if (sel_a !== 2'd2) begin
          fails++;
          $display("FAIL rstrun_pre_sel got %0d want 2", sel_a);
        end
      end
      if (i == 11) begin
        tests++;
        if (obs_a !== 6'b0) begin
          fails++;
          $display("FAIL rstrun_cleared got %b want %b", obs_a, 6'b0);
        end
      end
      if (i == 13) begin
        tests++;
        if ({busy_a, sel_a, sel_valid_a} !== 4'b1000) begin
          fails++;
          $display("FAIL rstrun_restart got %b want 1000", {busy_a, sel_a, sel_valid_a});
        end
      end
      rst = (i == 10); start = (i == 0) || (i == 12); stop = 1'b0; single = 1'b0; last = 2'd3;
    end
    rst = 1'b0;
  endtask

  task automatic test_fast();
    logic [1:0] want_sel [7];
    want_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      tests++;
      if (obs_b !== exp_v[1]) begin
        fails++;
        $display("FAIL fast_b[%0d] got %b want %b", i, obs_b, exp_v[1]);
      end
      if (i >= 1 && i <= 7) begin
        tests++;
        if ({sel_b, sel_valid_b} !== {want_sel[i-1], 1'b1}) begin
          fails++;
          $display("FAIL fast_seq[%0d] got sel=%0d valid=%b want sel=%0d valid=1", i, sel_b,
                   sel_valid_b, want_sel[i-1]);
        end
      end
      start = (i == 0); stop = (i == 10); single = 1'b0; last = 2'd2;
    end
    stop = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      tests++;
      if (obs_a !== exp_v[0]) begin
        fails++;
        $display("FAIL rand_a[%0d] got %b want %b", i, obs_a, exp_v[0]);
      end
      tests++;
      if (obs_b !== exp_v[1]) begin
        fails++;
        $display("FAIL rand_b[%0d] got %b want %b", i, obs_b, exp_v[1]);
      end
      rst    = ($urandom_range(0, 199) == 0);
      start  = ($urandom_range(0, 15) == 0);
      stop   = ($urandom_range(0, 39) == 0);
      single = 1'($urandom_range(0, 1));
      last   = 2'($urandom_range(0, 3));
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    single = 1'b0;
    last   = 2'd0;
    test_reset();
    test_continuous();
    test_single();
    test_start_stop();
    test_restart();
    test_reset_mid_run();
    test_fast();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
